// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared types and constants for the instruction fetch slice.
//   IADDR_W  : instruction word-address width
//   IDATA_W  : instruction width
//   INST_NOP : value held in empty queue slots out of reset
//   ientry_t : one queue entry, {addr, data}
//   push_t   : number of entries written into the queue on an edge
package ifetch_pkg;

   localparam int unsigned IADDR_W = 6;
   localparam int unsigned IDATA_W = 32;
   localparam logic [IDATA_W-1:0] INST_NOP = 32'h00000000;

   typedef struct packed {
      logic [IADDR_W-1:0] addr;
      logic [IDATA_W-1:0] data;
   } ientry_t;

   typedef enum logic [1:0] {
      PUSH_NONE = 2'd0,
      PUSH_ONE  = 2'd1,
      PUSH_TWO  = 2'd2
   } push_t;

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue -- circular instruction queue, two write slots, one read.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empty the queue (head/tail/count to 0), no write this edge
//   push_n      : how many of wr0/wr1 to append (wr0 first)
//   wr0, wr1    : entries to append
//   pop         : remove the head entry (ignored when empty)
//   valid       : queue not empty
//   head_entry  : registered head slot contents
//   count       : number of occupied entries (0..QDEPTH)
// The writer must never push more than QDEPTH - count entries.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int unsigned QDEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  push_t                        push_n,
   input  ientry_t                      wr0,
   input  ientry_t                      wr1,
   input  logic                         pop,
   output logic                         valid,
   output ientry_t                      head_entry,
   output logic [$clog2(QDEPTH+1)-1:0]  count
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = $clog2(QDEPTH+1);

   ientry_t       mem [QDEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] tail_p1;
   logic [1:0]    npush;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign tail_p1 = tail + PW'(1);

   always_comb begin
      npush = 2'd0;
      case (push_n)
         PUSH_ONE: npush = 2'd1;
         PUSH_TWO: npush = 2'd2;
         default:  npush = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            mem[i] <= '{addr: '0, data: INST_NOP};
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (npush != 2'd0) mem[tail]    <= wr0;
         if (npush == 2'd2) mem[tail_p1] <= wr1;
         // pointers wrap naturally since QDEPTH is a power of two
         tail  <= tail + PW'(npush);
         head  <= head + PW'(do_pop);
         count <= count + CW'(npush) - CW'(do_pop);
      end
   end

   assign valid      = (count != '0);
   assign head_entry = mem[head];

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl -- instruction fetch controller feeding a decode stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   fetch_en            : allow new fetches
//   imem_a1, imem_a2    : word addresses to the two instruction-memory read ports
//   imem_rd1, imem_rd2  : same-cycle read data for imem_a1 / imem_a2
//   redirect_valid/addr : flush the queue and restart fetching at redirect_addr
//   inst_valid/ready    : decode-side handshake
//   inst_data/addr      : head instruction and its word address
// Build option: define IFETCH_PAIR_FETCH_EN to fetch two words per cycle
// (fetch_pc and fetch_pc+1). Without it one word per cycle is fetched,
// imem_a2 mirrors imem_a1 and imem_rd2 is never written into the queue.
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int unsigned        QDEPTH   = 4,
   parameter logic [IADDR_W-1:0] RESET_PC = 6'd0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_en,
   output logic [IADDR_W-1:0] imem_a1,
   output logic [IADDR_W-1:0] imem_a2,
   input  logic [IDATA_W-1:0] imem_rd1,
   input  logic [IDATA_W-1:0] imem_rd2,
   input  logic               redirect_valid,
   input  logic [IADDR_W-1:0] redirect_addr,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [IDATA_W-1:0] inst_data,
   output logic [IADDR_W-1:0] inst_addr
);

   localparam int unsigned CW = $clog2(QDEPTH+1);

   logic [IADDR_W-1:0] fetch_pc;
   logic [IADDR_W-1:0] pc_p1;
   logic [CW-1:0]      count;
   logic [CW-1:0]      free;
   push_t              push_n;
   ientry_t            wr0;
   ientry_t            wr1;
   ientry_t            head_entry;
   logic               pop;

   assign pc_p1 = fetch_pc + IADDR_W'(1);   // 63 wraps to 0
   assign imem_a1 = fetch_pc;
`ifdef IFETCH_PAIR_FETCH_EN
   assign imem_a2 = pc_p1;
`else
   assign imem_a2 = fetch_pc;
`endif

   assign wr0 = '{addr: fetch_pc, data: imem_rd1};
   assign wr1 = '{addr: pc_p1,    data: imem_rd2};

   // free space is judged on the pre-pop count: a pop this edge only
   // makes room for the next cycle's fetch
   assign free = CW'(QDEPTH) - count;
   assign pop  = inst_valid && inst_ready;

   always_comb begin
      push_n = PUSH_NONE;
      if (fetch_en && !redirect_valid) begin
`ifdef IFETCH_PAIR_FETCH_EN
         if (free >= CW'(2))      push_n = PUSH_TWO;
         else if (free == CW'(1)) push_n = PUSH_ONE;
`else
         if (free != '0)          push_n = PUSH_ONE;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_addr;
      end else begin
         case (push_n)
            PUSH_ONE: fetch_pc <= pc_p1;
            PUSH_TWO: fetch_pc <= fetch_pc + IADDR_W'(2);
            default:  fetch_pc <= fetch_pc;
         endcase
      end
   end

   ifetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_valid),
      .push_n     (push_n),
      .wr0        (wr0),
      .wr1        (wr1),
      .pop        (pop),
      .valid      (inst_valid),
      .head_entry (head_entry),
      .count      (count)
   );

   assign inst_data = head_entry.data;
   assign inst_addr = head_entry.addr;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl -- directed, table-driven bench for ifetch_ctrl (QDEPTH=4).
// Expected values are hand-computed for both IFETCH_PAIR_FETCH_EN builds.
module tb_ifetch_ctrl;
   import ifetch_pkg::*;

   localparam int unsigned QDEPTH = 4;
`ifdef IFETCH_PAIR_FETCH_EN
   localparam bit PAIR = 1'b1;
`else
   localparam bit PAIR = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic [5:0]  imem_a1;
   logic [5:0]  imem_a2;
   logic [31:0] imem_rd1;
   logic [31:0] imem_rd2;
   logic        redirect_valid;
   logic [5:0]  redirect_addr;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [5:0]  inst_addr;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   ifetch_ctrl #(
      .QDEPTH   (QDEPTH),
      .RESET_PC (6'd0)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_a1        (imem_a1),
      .imem_a2        (imem_a2),
      .imem_rd1       (imem_rd1),
      .imem_rd2       (imem_rd2),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_addr      (inst_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // bench-side instruction ROM: each word tagged with its own address
   function automatic logic [31:0] rom_word(input logic [5:0] a);
      return {16'hC0DE, 8'h5A, 2'b00, a};
   endfunction

   assign imem_rd1 = rom_word(imem_a1);
   assign imem_rd2 = rom_word(imem_a2);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       en;
      logic       rdy;
      logic       redir;
      logic [5:0] raddr;
      logic       exp_valid;
      logic [5:0] exp_addr;
      logic [5:0] exp_a1;
   } vec_t;

   localparam int unsigned NVEC = 18;
   vec_t tbl [NVEC];

   function automatic vec_t v(input bit en, input bit rdy, input bit redir, input int ra,
                              input bit ev, input int ea, input int a1);
      vec_t r;
      r.en        = en;
      r.rdy       = rdy;
      r.redir     = redir;
      r.raddr     = 6'(ra);
      r.exp_valid = ev;
      r.exp_addr  = 6'(ea);
      r.exp_a1    = 6'(a1);
      return r;
   endfunction

   task automatic reset_dut();
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 6'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] ea2;
      logic [5:0] exp_a1_v;

`ifdef IFETCH_PAIR_FETCH_EN
      tbl[0]  = v(1,1,0,0,  1,0,2);
      tbl[1]  = v(1,1,0,0,  1,1,4);
      tbl[2]  = v(1,1,0,0,  1,2,5);
      tbl[3]  = v(1,1,0,0,  1,3,6);
      tbl[4]  = v(1,0,0,0,  1,3,7);
      tbl[5]  = v(1,0,0,0,  1,3,7);
      tbl[6]  = v(1,0,0,0,  1,3,7);
      tbl[7]  = v(1,0,0,0,  1,3,7);
      tbl[8]  = v(1,1,0,0,  1,4,7);
      tbl[9]  = v(1,1,0,0,  1,5,8);
      tbl[10] = v(0,1,0,0,  1,6,8);
      tbl[11] = v(0,0,0,0,  1,6,8);
      tbl[12] = v(1,1,1,9,  0,0,9);
      tbl[13] = v(1,1,0,0,  1,9,11);
      tbl[14] = v(1,1,1,63, 0,0,63);
      tbl[15] = v(1,1,0,0,  1,63,1);
      tbl[16] = v(1,1,0,0,  1,0,3);
      tbl[17] = v(0,1,0,0,  1,1,3);
`else
      tbl[0]  = v(1,1,0,0,  1,0,1);
      tbl[1]  = v(1,1,0,0,  1,1,2);
      tbl[2]  = v(1,1,0,0,  1,2,3);
      tbl[3]  = v(1,1,0,0,  1,3,4);
      tbl[4]  = v(1,0,0,0,  1,3,5);
      tbl[5]  = v(1,0,0,0,  1,3,6);
      tbl[6]  = v(1,0,0,0,  1,3,7);
      tbl[7]  = v(1,0,0,0,  1,3,7);
      tbl[8]  = v(1,1,0,0,  1,4,7);
      tbl[9]  = v(1,1,0,0,  1,5,8);
      tbl[10] = v(0,1,0,0,  1,6,8);
      tbl[11] = v(0,0,0,0,  1,6,8);
      tbl[12] = v(1,1,1,9,  0,0,9);
      tbl[13] = v(1,1,0,0,  1,9,10);
      tbl[14] = v(1,1,1,63, 0,0,63);
      tbl[15] = v(1,1,0,0,  1,63,0);
      tbl[16] = v(1,1,0,0,  1,0,1);
      tbl[17] = v(0,1,0,0,  0,0,1);
`endif

      // ---- reset state ----
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 6'd0;
      #12;
      check("reset inst_valid", 32'(inst_valid), 32'd0);
      check("reset inst_data",  inst_data, 32'h0);
      check("reset inst_addr",  32'(inst_addr), 32'd0);
      check("reset imem_a1",    32'(imem_a1), 32'd0);
      check("reset imem_a2",    32'(imem_a2), PAIR ? 32'd1 : 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- table: streaming, back-pressure, redirects, wrap at 63 ----
      for (int unsigned i = 0; i < NVEC; i++) begin
         fetch_en       = tbl[i].en;
         inst_ready     = tbl[i].rdy;
         redirect_valid = tbl[i].redir;
         redirect_addr  = tbl[i].raddr;
         step();
         exp_a1_v = tbl[i].exp_a1;
         ea2 = PAIR ? exp_a1_v + 6'd1 : exp_a1_v;
         check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) begin
            check($sformatf("row%0d inst_addr", i), 32'(inst_addr), 32'(tbl[i].exp_addr));
            check($sformatf("row%0d inst_data", i), inst_data, rom_word(tbl[i].exp_addr));
         end
         check($sformatf("row%0d imem_a1", i), 32'(imem_a1), 32'(exp_a1_v));
         check($sformatf("row%0d imem_a2", i), 32'(imem_a2), 32'(ea2));
      end

      // ---- stall until full, then drain in order ----
      reset_dut();
      fetch_en   = 1'b1;
      inst_ready = 1'b0;
      repeat (10) step();
      check("stall imem_a1",    32'(imem_a1), 32'd4);
      check("stall inst_valid", 32'(inst_valid), 32'd1);
      check("stall inst_addr",  32'(inst_addr), 32'd0);
      inst_ready = 1'b1;
      for (int unsigned k = 1; k <= 4; k++) begin
         step();
         check($sformatf("drain%0d inst_valid", k), 32'(inst_valid), 32'd1);
         check($sformatf("drain%0d inst_addr", k), 32'(inst_addr), 32'(k));
         check($sformatf("drain%0d inst_data", k), inst_data, rom_word(6'(k)));
      end

      // ---- one free slot: single push only ----
      reset_dut();
      fetch_en = 1'b1; inst_ready = 1'b0; step();
      fetch_en = 1'b0; inst_ready = 1'b1; step();
      fetch_en = 1'b1; inst_ready = 1'b0; step();
      check("free1 a1 e3", 32'(imem_a1), PAIR ? 32'd4 : 32'd2);
      step();
      check("free1 a1 e4", 32'(imem_a1), PAIR ? 32'd5 : 32'd3);
      step();
      check("free1 a1 e5", 32'(imem_a1), PAIR ? 32'd5 : 32'd4);
      check("free1 head",  32'(inst_addr), 32'd1);

      // ---- asynchronous reset pulse mid-stream ----
      reset_dut();
      fetch_en = 1'b1; inst_ready = 1'b1;
      repeat (3) step();
      check("pre-pulse inst_valid", 32'(inst_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("pulse inst_valid", 32'(inst_valid), 32'd0);
      check("pulse inst_data",  inst_data, 32'h0);
      check("pulse imem_a1",    32'(imem_a1), 32'd0);
      rst_n = 1'b1;
      step();
      check("restart inst_valid", 32'(inst_valid), 32'd1);
      check("restart inst_addr",  32'(inst_addr), 32'd0);
      check("restart inst_data",  inst_data, rom_word(6'd0));
      step();
      check("restart2 inst_addr", 32'(inst_addr), 32'd1);
      check("restart2 imem_a2",   32'(imem_a2), PAIR ? 32'(imem_a1 + 6'd1) : 32'(imem_a1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, instruction-queue depth in entries (power of 2, >= 2).
REQ-002 SHALL have parameter RESET_PC, default 6'd0, word address fetched first after reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_en  input  1  permits new fetches when high.
REQ-006 SHALL have ports imem_a1 and imem_a2  output  6 each  word addresses to the instruction memory's two read ports.
REQ-007 SHALL have ports imem_rd1 and imem_rd2  input  32 each  combinational read data for imem_a1/imem_a2, same cycle.
REQ-008 SHALL have ports redirect_valid  input  1 and redirect_addr  input  6  branch/jump target request.
REQ-009 SHALL have ports inst_valid  output  1, inst_ready  input  1, inst_data  output  32, inst_addr  output  6  decode-side valid/ready stream.

Function
REQ-010 SHALL hold a 6-bit fetch_pc; imem_a1 = fetch_pc, imem_a2 = fetch_pc+1 mod 64 (63 -> 0).
REQ-011 SHALL hold a circular queue of {addr, data} entries with head, tail and count (0..QDEPTH).
REQ-012 SHALL assert inst_valid iff count != 0; inst_data/inst_addr come from the head entry, driven from registers.
REQ-013 SHALL pop the head on a rising edge where inst_valid && inst_ready.
REQ-014 SHALL compute free = QDEPTH - count using count before this edge's pop (a pop frees space only next cycle).
REQ-015 With fetch_en high and no redirect: free >= 2 -> push {a1,rd1} then {a2,rd2}, fetch_pc += 2; free == 1 -> push {a1,rd1} only, fetch_pc += 1; free == 0 -> no push, fetch_pc held.
REQ-016 With fetch_en low: no push, fetch_pc held, pops continue.
REQ-017 Simultaneous push and pop SHALL update count by pushes minus pops in one edge; queue never overflows nor underflows.
REQ-018 redirect_valid on an edge SHALL take priority: count, head, tail := 0; fetch_pc := redirect_addr; no push; any concurrent pop discarded; inst_valid low the following cycle.
REQ-019 Fetch latency SHALL be one cycle: instruction at fetch_pc visible on inst_data the cycle after the push edge.
REQ-020 Head/tail pointers SHALL wrap modulo QDEPTH.

Reset
REQ-021 On rst_n low, asynchronously: fetch_pc = RESET_PC, count/head/tail = 0, inst_valid = 0, inst_data = 32'h0, inst_addr = 6'd0.
REQ-022 Reset asserted mid-operation SHALL discard all queued entries; first fetch after release is at RESET_PC.

Configuration
REQ-023 Macro IFETCH_PAIR_FETCH_EN SHALL select dual-port fetch.
REQ-024 Defined: behaviour per REQ-015 (up to 2 pushes per cycle).
REQ-025 Undefined: at most one push per cycle ({a1,rd1}), fetch_pc += 1, imem_a2 driven equal to imem_a1, imem_rd2 ignored.

Structure
REQ-026 Package ifetch_pkg SHALL hold IADDR_W = 6, IDATA_W = 32, INST_NOP = 32'h00000000 and the queue entry typedef {addr, data}.
REQ-027 Sub-module ifetch_queue SHALL implement the 2-write/1-read circular queue; ifetch_ctrl holds fetch_pc and push/redirect control.

Verification
REQ-028 Reset release, fetch_en=1, inst_ready=1, ROM[0..3]=A,B,C,D -> inst_valid high from cycle 2, stream A@0,B@1,C@2,D@3 in order, no gaps once primed.
REQ-029 inst_ready=0 for 10 cycles, QDEPTH=4 -> count saturates at 4, fetch_pc stops at 4, imem_a1=4; release -> entries 0..3 then 4 delivered.
REQ-030 count=3 with no pop -> single push of address fetch_pc, fetch_pc increments by 1 only.
REQ-031 redirect_valid with redirect_addr=9 while queue holds 3 entries and inst_ready=1 -> next cycle inst_valid=0, following cycle inst_addr=9, data ROM[9].
REQ-032 Redirect to 63, QDEPTH=4 -> imem_a1=63, imem_a2=0, entries 63 then 0 delivered, fetch_pc=1 after the edge.
REQ-033 rst_n pulsed low mid-stream for 1 ns between edges -> inst_valid drops immediately; after release stream restarts at RESET_PC; repeat REQ-028 with IFETCH_PAIR_FETCH_EN undefined -> same order, imem_a2==imem_a1 every cycle.
